// File: rtl/grant_controller_rr.sv
// rtl/grant_controller_rr.sv - edge/level event capture with fixed-priority or round-robin grant
module grant_controller_rr #(
    parameter int MAX_DESC = 16,
    parameter int EDGE_TYP = 1,
    parameter int ARB_MODE = 1,
    parameter int IDX_W    = $clog2(MAX_DESC),
    parameter int CNT_W    = $clog2(MAX_DESC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAX_DESC-1:0] din,
    input  logic [MAX_DESC-1:0] clr,
    output logic [MAX_DESC-1:0] req_out,
    output logic                gnt_vld,
    input  logic                gnt_rdy,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic [MAX_DESC-1:0] gnt_onehot,
    output logic [CNT_W-1:0]    pend_cnt,
    output logic                ovf
);

    logic [MAX_DESC-1:0] din_ff_q;
    logic                armed_q;
    logic [MAX_DESC-1:0] pend_q, pend_d;
    logic                gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [MAX_DESC-1:0] gnt_oh_q, gnt_oh_d;
    logic                ovf_q, ovf_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [MAX_DESC-1:0] ev;
    logic [MAX_DESC-1:0] held;
    logic [MAX_DESC-1:0] lvl_req;
    logic [MAX_DESC-1:0] arb_req;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [MAX_DESC-1:0] win_oh;
    logic [MAX_DESC-1:0] load_vec;
    logic                can_load;
    logic                load;
    int                  start;
    int                  j;
    logic [IDX_W-1:0]    jj;

    // Until armed, din_ff only tracks din so a level present at reset release is not an edge
    always_comb begin
        ev = '0;
        if (armed_q) begin
            if (EDGE_TYP == 0) begin
                ev = ~din & din_ff_q;
            end else if (EDGE_TYP == 1) begin
                ev = din & ~din_ff_q;
            end
        end
    end

    always_comb begin
        held    = gnt_vld_q ? gnt_oh_q : '0;
        lvl_req = din_ff_q & ~clr & ~held;
        if (EDGE_TYP == 2) begin
            req_out = lvl_req;
            arb_req = lvl_req;
        end else begin
            req_out = pend_q;
            arb_req = pend_q & ~held;
        end
    end

    // Circular search from start; fixed priority is the same search anchored at slot 0
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        j         = 0;
        jj        = '0;
        start     = (ARB_MODE == 1) ? int'(ptr_q) + 1 : 0;
        for (int k = 0; k < MAX_DESC; k++) begin
            j = start + k;
            if (j >= MAX_DESC) begin
                j = j - MAX_DESC;
            end
            jj = IDX_W'(j);
            if (!win_found && arb_req[jj]) begin
                win_found  = 1'b1;
                win_idx    = jj;
                win_oh[jj] = 1'b1;
            end
        end
    end

    always_comb begin
        can_load  = ~gnt_vld_q | gnt_rdy;
        load      = can_load & win_found;
        load_vec  = load ? win_oh : '0;
        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        ptr_d     = ptr_q;
        if (load) begin
            gnt_vld_d = 1'b1;
            gnt_idx_d = win_idx;
            gnt_oh_d  = win_oh;
            if (ARB_MODE == 1) begin
                ptr_d = win_idx;
            end
        end else if (can_load) begin
            gnt_vld_d = 1'b0;
            gnt_oh_d  = '0;
        end
    end

    // A fresh event always wins over clear/load so it is never dropped
    always_comb begin
        if (EDGE_TYP == 2) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else begin
            pend_d = ev | (pend_q & ~clr & ~load_vec);
            ovf_d  = |(ev & pend_q & ~load_vec);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_ff_q  <= '0;
            armed_q   <= 1'b0;
            pend_q    <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= IDX_W'(MAX_DESC - 1);
        end else begin
            din_ff_q  <= din;
            armed_q   <= 1'b1;
            pend_q    <= pend_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_vld    = gnt_vld_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_oh_q;
    assign ovf        = ovf_q;
    assign pend_cnt   = CNT_W'($countones(req_out));

endmodule

// File: tb/tb_grant_controller_rr.sv
// tb/tb_grant_controller_rr.sv - scoreboard bench for grant_controller_rr
module tb_grant_controller_rr;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [15:0] clr;
    logic        gnt_rdy;
    logic [1:0]  sel;

    logic [15:0] fp_req, fp_oh;
    logic        fp_vld, fp_ovf;
    logic [3:0]  fp_idx;
    logic [4:0]  fp_cnt;

    logic [4:0]  rr_req, rr_oh;
    logic        rr_vld, rr_ovf;
    logic [2:0]  rr_idx;
    logic [2:0]  rr_cnt;

    logic [15:0] ng_req, ng_oh;
    logic        ng_vld, ng_ovf;
    logic [3:0]  ng_idx;
    logic [4:0]  ng_cnt;

    logic [15:0] lv_req, lv_oh;
    logic        lv_vld, lv_ovf;
    logic [3:0]  lv_idx;
    logic [4:0]  lv_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    int mon_exp;

    logic        m_vld;
    logic [3:0]  m_idx;
    logic [15:0] m_oh;

    grant_controller_rr #(.MAX_DESC(16), .EDGE_TYP(1), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr), .req_out(fp_req),
        .gnt_vld(fp_vld), .gnt_rdy(gnt_rdy), .gnt_idx(fp_idx), .gnt_onehot(fp_oh),
        .pend_cnt(fp_cnt), .ovf(fp_ovf));

    grant_controller_rr #(.MAX_DESC(5), .EDGE_TYP(1), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .din(din[4:0]), .clr(clr[4:0]), .req_out(rr_req),
        .gnt_vld(rr_vld), .gnt_rdy(gnt_rdy), .gnt_idx(rr_idx), .gnt_onehot(rr_oh),
        .pend_cnt(rr_cnt), .ovf(rr_ovf));

    grant_controller_rr #(.MAX_DESC(16), .EDGE_TYP(0), .ARB_MODE(1)) u_ng (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr), .req_out(ng_req),
        .gnt_vld(ng_vld), .gnt_rdy(gnt_rdy), .gnt_idx(ng_idx), .gnt_onehot(ng_oh),
        .pend_cnt(ng_cnt), .ovf(ng_ovf));

    grant_controller_rr #(.MAX_DESC(16), .EDGE_TYP(2), .ARB_MODE(0)) u_lv (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr), .req_out(lv_req),
        .gnt_vld(lv_vld), .gnt_rdy(gnt_rdy), .gnt_idx(lv_idx), .gnt_onehot(lv_oh),
        .pend_cnt(lv_cnt), .ovf(lv_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    always_comb begin
        m_vld = 1'b0;
        m_idx = '0;
        m_oh  = '0;
        case (sel)
            2'd0: begin m_vld = fp_vld; m_idx = fp_idx; m_oh = fp_oh; end
            2'd1: begin m_vld = rr_vld; m_idx = {1'b0, rr_idx}; m_oh = {11'd0, rr_oh}; end
            2'd2: begin m_vld = ng_vld; m_idx = ng_idx; m_oh = ng_oh; end
            default: begin m_vld = 1'b0; m_idx = '0; m_oh = '0; end
        endcase
    end

    // Every accepted grant of the observed instance must match the next expected index
    always @(negedge clk) begin
        if (rst_n && sel != 2'd3 && m_vld && gnt_rdy) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("sb_gnt_idx", m_idx, mon_exp);
            if (mon_exp >= 0) begin
                chk("sb_gnt_onehot", m_oh, 64'd1 << mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [1:0] s);
        sel     = 2'd3;
        rst_n   = 1'b0;
        din     = d;
        clr     = '0;
        gnt_rdy = 1'b0;
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        sel = s;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            cyc(1);
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        sel     = 2'd3;
        rst_n   = 1'b0;
        din     = 16'hFFFF;
        clr     = '0;
        gnt_rdy = 1'b0;

        // din held high through reset is not an event
        cyc(2);
        chk("rst_vld", fp_vld, 0);
        chk("rst_idx", fp_idx, 0);
        chk("rst_onehot", fp_oh, 0);
        chk("rst_ovf", fp_ovf, 0);
        chk("rst_req", fp_req, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("arm_vld", fp_vld, 0);
            chk("arm_cnt", fp_cnt, 0);
        end
        chk("arm_rr_cnt", rr_cnt, 0);

        // Fixed priority, two simultaneous rises
        do_reset(16'h0000, 2'd0);
        gnt_rdy = 1'b1;
        din = 16'h0024;
        exp_q.push_back(2);
        exp_q.push_back(5);
        cyc(1);
        chk("fp_cnt_2", fp_cnt, 2);
        chk("fp_vld_lat", fp_vld, 0);
        cyc(1);
        chk("fp_vld_up", fp_vld, 1);
        chk("fp_idx_a", fp_idx, 2);
        chk("fp_cnt_1", fp_cnt, 1);
        cyc(1);
        chk("fp_idx_b", fp_idx, 5);
        chk("fp_cnt_0", fp_cnt, 0);
        cyc(1);
        chk("fp_vld_down", fp_vld, 0);
        drain();

        // Round-robin, MAX_DESC=5, including wrap from ptr=3
        do_reset(16'h0000, 2'd1);
        gnt_rdy = 1'b1;
        din = 16'h001F;
        for (int i = 0; i < 5; i++) exp_q.push_back(i);
        cyc(1);
        chk("rr_cnt_5", rr_cnt, 5);
        chk("rr_req_all", rr_req, 5'h1F);
        drain();
        din = 16'h0000;
        cyc(1);
        din = 16'h0008;
        exp_q.push_back(3);
        cyc(3);
        din = 16'h0019;
        exp_q.push_back(4);
        exp_q.push_back(0);
        cyc(1);
        chk("rr_cnt_2", rr_cnt, 2);
        drain();
        chk("rr_ovf", rr_ovf, 0);

        // Back-pressure holds the output; new edge waits
        do_reset(16'h0000, 2'd0);
        din = 16'h0008;
        exp_q.push_back(3);
        cyc(2);
        chk("bp_vld0", fp_vld, 1);
        chk("bp_idx0", fp_idx, 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                din = 16'h000A;
                exp_q.push_back(1);
            end
            cyc(1);
            chk("bp_idx", fp_idx, 3);
            chk("bp_onehot", fp_oh, 16'h0008);
            chk("bp_vld", fp_vld, 1);
        end
        gnt_rdy = 1'b1;
        cyc(1);
        chk("bp_next_idx", fp_idx, 1);
        chk("bp_next_vld", fp_vld, 1);
        drain();

        // Overflow and clear interactions
        do_reset(16'h0000, 2'd0);
        din = 16'h0001;
        exp_q.push_back(0);
        cyc(2);
        din = 16'h0081;
        exp_q.push_back(7);
        cyc(1);
        chk("ov_first", fp_ovf, 0);
        chk("ov_pend7", fp_req[7], 1);
        din = 16'h0001;
        cyc(1);
        din = 16'h0081;
        cyc(1);
        chk("ov_pulse", fp_ovf, 1);
        cyc(1);
        chk("ov_clear", fp_ovf, 0);
        din = 16'h0281;
        clr = 16'h0200;
        exp_q.push_back(9);
        cyc(1);
        clr = 16'h0000;
        chk("clr_set_wins", fp_req[9], 1);
        din = 16'h0681;
        cyc(1);
        clr = 16'h0400;
        cyc(1);
        clr = 16'h0000;
        chk("clr_pend10", fp_req[10], 0);
        chk("clr_cnt", fp_cnt, 2);
        gnt_rdy = 1'b1;
        drain();
        cyc(2);
        chk("ov_single", fp_vld, 0);

        // Negedge capture
        do_reset(16'h0010, 2'd2);
        gnt_rdy = 1'b1;
        cyc(1);
        chk("ng_cnt0", ng_cnt, 0);
        din = 16'h0040;
        exp_q.push_back(4);
        cyc(1);
        chk("ng_cnt1", ng_cnt, 1);
        chk("ng_req", ng_req, 16'h0010);
        drain();
        cyc(2);
        chk("ng_vld_end", ng_vld, 0);
        chk("ng_ovf", ng_ovf, 0);

        // Level mode: alternate-cycle regrant while held, clr masks
        do_reset(16'h0000, 2'd3);
        gnt_rdy = 1'b1;
        din = 16'h0010;
        cyc(1);
        chk("lv_vld0", lv_vld, 0);
        chk("lv_req0", lv_req, 16'h0010);
        chk("lv_cnt0", lv_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("lv_alt_vld", lv_vld, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) begin
                chk("lv_idx", lv_idx, 4);
                chk("lv_onehot", lv_oh, 16'h0010);
                chk("lv_req_masked", lv_req, 0);
            end else begin
                chk("lv_req_open", lv_req, 16'h0010);
            end
        end
        din = 16'h0000;
        cyc(2);
        chk("lv_drop_vld", lv_vld, 0);
        chk("lv_ovf", lv_ovf, 0);
        din = 16'h0010;
        clr = 16'h0010;
        cyc(1);
        chk("lv_clr_req", lv_req, 0);
        cyc(1);
        chk("lv_clr_vld", lv_vld, 0);
        clr = 16'h0000;
        din = 16'h0000;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
